// File: rtl/pim_pkg.sv
// pim_pkg: shared op-code and state encodings for the BRAM processing-in-memory engine
package pim_pkg;
    localparam int OP_W = 3;
    typedef enum logic [OP_W-1:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL, OP_MAXU, OP_DOT
    } pim_op_e;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WRITE, S_DONE} pim_state_e;
endpackage

// File: rtl/pim_alu.sv
// pim_alu: combinational element operation; DOT folds the low-half product into acc
module pim_alu
    import pim_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  pim_op_e               op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] acc,
    output logic [DATA_WIDTH-1:0] value
);
    localparam int H = DATA_WIDTH / 2;
    logic [DATA_WIDTH-1:0] prod, half_prod;
    assign prod      = a * b;
    assign half_prod = DATA_WIDTH'(a[H-1:0]) * DATA_WIDTH'(b[H-1:0]);
    always_comb begin
        value = '0;
        case (op)
            OP_ADD:  value = a + b;
            OP_SUB:  value = a - b;
            OP_AND:  value = a & b;
            OP_OR:   value = a | b;
            OP_XOR:  value = a ^ b;
            OP_MUL:  value = prod;
            OP_MAXU: value = a > b ? a : b;
            OP_DOT:  value = acc + half_prod;
            default: value = '0;
        endcase
    end
endmodule

// File: rtl/bram_pim_ctrl.sv
// bram_pim_ctrl: streams element pairs out of a dual-port BRAM, applies an op, writes back in order
module bram_pim_ctrl
    import pim_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [OP_W-1:0]       cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_src_a,
    input  logic [ADDR_WIDTH-1:0] cmd_src_b,
    input  logic [ADDR_WIDTH-1:0] cmd_dst,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    output logic                  bram_wea,
    output logic                  bram_web,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    output logic [ADDR_WIDTH-1:0] bram_addrb,
    output logic [DATA_WIDTH-1:0] bram_dia,
    output logic [DATA_WIDTH-1:0] bram_dib,
    input  logic [DATA_WIDTH-1:0] bram_doa,
    input  logic [DATA_WIDTH-1:0] bram_dob,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);
    pim_state_e state, next;
    pim_op_e op_q;
    logic [ADDR_WIDTH-1:0] src_a_q, src_b_q, dst_q, len_q, idx;
    logic [DATA_WIDTH-1:0] acc, value;
    logic last, is_dot, wr, accept;

    pim_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .op(op_q), .a(bram_doa), .b(bram_dob), .acc(acc), .value(value)
    );

    assign bram_web = 1'b0;
    assign bram_dib = '0;
    assign accept   = state == S_IDLE && cmd_valid;

    // Outputs decode from state only, so an asynchronous reset clears them in the same cycle
    always_comb begin
        last       = idx == len_q;
        is_dot     = op_q == OP_DOT;
        wr         = state == S_WRITE && (!is_dot || last);
        next       = state == S_IDLE  ? (cmd_valid ? S_ISSUE : S_IDLE) :
                     state == S_ISSUE ? S_WRITE :
                     state == S_WRITE ? (last ? S_DONE : S_ISSUE) : S_IDLE;
        cmd_ready  = state == S_IDLE;
        busy       = state != S_IDLE;
        done       = state == S_DONE;
        bram_wea   = wr;
        bram_addra = state == S_ISSUE ? src_a_q + idx :
                     wr ? dst_q + (is_dot ? '0 : idx) : '0;
        bram_addrb = state == S_ISSUE ? src_b_q + idx : '0;
        bram_dia   = wr ? value : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            op_q    <= OP_ADD;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx     <= '0;
            acc     <= '0;
            result  <= '0;
        end else begin
            state <= next;
            if (accept) begin
                op_q    <= pim_op_e'(cmd_op);
                src_a_q <= cmd_src_a;
                src_b_q <= cmd_src_b;
                dst_q   <= cmd_dst;
                len_q   <= cmd_len;
                idx     <= '0;
                acc     <= '0;
            end
            if (state == S_WRITE) begin
                idx <= idx + 1'b1;
                if (is_dot) acc <= value;
            end
            if (wr) result <= value;
        end
    end
endmodule

// File: tb/tb_bram_pim_ctrl.sv
// tb_bram_pim_ctrl: directed commands against a BRAM model, writes scored against a reference memory
module tb_bram_pim_ctrl;
    typedef struct packed {logic [5:0] addr; logic [15:0] data;} wr_t;

    logic clk = 0, rst = 1, cmd_valid = 0;
    logic [2:0] cmd_op = 0;
    logic [5:0] cmd_src_a = 0, cmd_src_b = 0, cmd_dst = 0, cmd_len = 0;
    logic cmd_ready, bram_wea, bram_web, busy, done;
    logic [5:0] bram_addra, bram_addrb;
    logic [15:0] bram_dia, bram_dib, bram_doa, bram_dob, result;

    logic [15:0] mem [64];
    logic [15:0] ref_mem [64];
    wr_t exp_q[$];
    wr_t mon_e;
    logic [15:0] last_exp;
    int checks = 0, failures = 0, wcount = 0;
    int add_exp[4] = '{11, 22, 33, 44};
    int wrap_exp[4] = '{15, 26, 31, 42};

    bram_pim_ctrl dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .bram_wea(bram_wea), .bram_web(bram_web), .bram_addra(bram_addra), .bram_addrb(bram_addrb),
        .bram_dia(bram_dia), .bram_dib(bram_dib), .bram_doa(bram_doa), .bram_dob(bram_dob),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Read-first registered BRAM
    always @(posedge clk) begin
        bram_doa <= mem[bram_addra];
        bram_dob <= mem[bram_addrb];
        if (bram_wea) mem[bram_addra] = bram_dia;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("portb_ro", 32'({bram_web, bram_dib}), 0);
            if (bram_wea) begin
                wcount++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL unexpected_write observed=%0h:%0h expected=none", bram_addra, bram_dia);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("write_addr", 32'(bram_addra), 32'(mon_e.addr));
                    check("write_data", 32'(bram_dia), 32'(mon_e.data));
                end
            end
        end
    end

    function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = a * b;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return p[15:0];
            default: return a > b ? a : b;
        endcase
    endfunction

    task automatic put(input logic [5:0] a, input logic [15:0] v);
        mem[a] = v;
        ref_mem[a] = v;
    endtask

    // Sequential element-by-element model, so overlapping regions see earlier writes
    task automatic model_cmd(input logic [2:0] op, input logic [5:0] sa, input logic [5:0] sb,
                             input logic [5:0] d, input logic [5:0] len);
        logic [15:0] acc, v;
        logic [5:0] ia, ib, id;
        acc = 0;
        for (int n = 0; n <= int'(len); n++) begin
            ia = sa + 6'(n);
            ib = sb + 6'(n);
            id = d + 6'(n);
            if (op == 3'd7) begin
                acc = acc + 16'(ref_mem[ia][7:0]) * 16'(ref_mem[ib][7:0]);
                if (n == int'(len)) begin
                    ref_mem[d] = acc;
                    exp_q.push_back('{d, acc});
                    last_exp = acc;
                end
            end else begin
                v = alu_ref(op, ref_mem[ia], ref_mem[ib]);
                ref_mem[id] = v;
                exp_q.push_back('{id, v});
                last_exp = v;
            end
        end
    endtask

    task automatic run_cmd(input string name, input logic [2:0] op, input logic [5:0] sa,
                           input logic [5:0] sb, input logic [5:0] d, input logic [5:0] len);
        int k, w0;
        model_cmd(op, sa, sb, d, len);
        @(negedge clk);
        check({name, "_ready"}, 32'(cmd_ready), 1);
        cmd_valid = 1; cmd_op = op; cmd_src_a = sa; cmd_src_b = sb; cmd_dst = d; cmd_len = len;
        @(posedge clk);
        w0 = wcount;
        #1;
        cmd_valid = 0; cmd_op = ~op; cmd_src_a = ~sa; cmd_src_b = ~sb; cmd_dst = ~d; cmd_len = 6'd63;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check({name, "_busy"}, 32'({busy, cmd_ready}), 32'b10);
                cmd_valid = 1;
            end else if (k == 2) cmd_valid = 0;
        end while (!done && k < 300);
        check({name, "_latency"}, k, 2 * (int'(len) + 1) + 1);
        check({name, "_writes"}, wcount - w0, op == 3'd7 ? 1 : int'(len) + 1);
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_result"}, 32'(result), 32'(last_exp));
        @(negedge clk);
        check({name, "_done_pulse"}, 32'({done, busy}), 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) put(6'(i), 16'h0);
        #1;
        check("rst_ctrl", 32'({cmd_ready, busy, done}), 32'b100);
        check("rst_result", 32'(result), 0);
        check("rst_bram", 32'({bram_wea, bram_addra, bram_addrb, bram_dia}), 0);
        repeat (2) @(negedge clk);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            put(6'(i), 16'(i + 1));
            put(6'(8 + i), 16'(10 * (i + 1)));
        end
        run_cmd("add", 3'd0, 6'd0, 6'd8, 6'd16, 6'd3);
        for (int i = 0; i < 4; i++) check("add_mem", 32'(mem[16 + i]), add_exp[i]);
        run_cmd("dot", 3'd7, 6'd0, 6'd8, 6'd20, 6'd3);
        check("dot_mem", 32'(mem[20]), 300);
        check("dot_result", 32'(result), 300);
        put(6'd40, 16'h0000);
        put(6'd41, 16'h0001);
        run_cmd("sub", 3'd1, 6'd40, 6'd41, 6'd42, 6'd0);
        check("sub_wrap", 32'(mem[42]), 32'hFFFF);
        put(6'd43, 16'h0100);
        run_cmd("mul", 3'd5, 6'd43, 6'd43, 6'd44, 6'd0);
        check("mul_wrap", 32'(mem[44]), 0);
        put(6'd62, 16'd5);
        put(6'd63, 16'd6);
        run_cmd("addr_wrap", 3'd0, 6'd62, 6'd8, 6'd50, 6'd3);
        for (int i = 0; i < 4; i++) check("addr_wrap_mem", 32'(mem[50 + i]), wrap_exp[i]);
        put(6'd4, 16'd1);
        put(6'd5, 16'd2);
        put(6'd6, 16'd7);
        run_cmd("inplace", 3'd0, 6'd4, 6'd5, 6'd4, 6'd1);
        check("inplace_m4", 32'(mem[4]), 3);
        check("inplace_m5", 32'(mem[5]), 9);
        put(6'd30, 16'd5);
        for (int i = 48; i < 51; i++) put(6'(i), 16'd1);
        run_cmd("raw", 3'd0, 6'd30, 6'd48, 6'd31, 6'd2);
        check("raw_m33", 32'(mem[33]), 8);
        put(6'd56, 16'hF0F0);
        put(6'd57, 16'h1234);
        put(6'd58, 16'h8000);
        put(6'd59, 16'h0001);
        run_cmd("and", 3'd2, 6'd56, 6'd8, 6'd36, 6'd3);
        run_cmd("or", 3'd3, 6'd56, 6'd16, 6'd36, 6'd3);
        run_cmd("xor", 3'd4, 6'd56, 6'd0, 6'd36, 6'd3);
        run_cmd("maxu", 3'd6, 6'd56, 6'd16, 6'd36, 6'd3);
        check("maxu_m36", 32'(mem[36]), 32'hF0F0);
        check("maxu_m38", 32'(mem[38]), 32'h8000);
        for (int i = 24; i < 28; i++) put(6'(i), 16'hDEAD);
        model_cmd(3'd0, 6'd0, 6'd8, 6'd24, 6'd3);
        @(negedge clk);
        cmd_valid = 1; cmd_op = 3'd0; cmd_src_a = 6'd0; cmd_src_b = 6'd8; cmd_dst = 6'd24; cmd_len = 6'd3;
        @(posedge clk);
        #1 cmd_valid = 0;
        repeat (4) @(posedge clk);
        #2 rst = 1;
        #1;
        check("abort_ctrl", 32'({cmd_ready, busy, done}), 32'b100);
        check("abort_bram", 32'({bram_wea, bram_addra, bram_addrb, bram_dia}), 0);
        check("abort_result", 32'(result), 0);
        repeat (3) @(negedge clk);
        check("abort_m24", 32'(mem[24]), 11);
        check("abort_m25", 32'(mem[25]), 22);
        check("abort_m26", 32'(mem[26]), 32'hDEAD);
        check("abort_m27", 32'(mem[27]), 32'hDEAD);
        check("abort_pending", exp_q.size(), 2);
        exp_q.delete();
        ref_mem[26] = 16'hDEAD;
        ref_mem[27] = 16'hDEAD;
        rst = 0;
        run_cmd("post_rst", 3'd4, 6'd0, 6'd8, 6'd24, 6'd3);
        check("post_rst_m26", 32'(mem[26]), 32'(ref_mem[26]));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
